// File: rtl/conv_output_writer.sv
// rtl/conv_output_writer.sv - packs convolution results MSB-first into SRAM words
// Completed words wait in a pending register until the controller's commit strobe writes them out.
module conv_output_writer #(
  parameter int                DATA_W    = 16,
  parameter int                RES_W     = 1,
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] ADDR_BASE = '0
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              conv_valid,
  input  logic [RES_W-1:0]  conv_result,
  input  logic              row_last,
  input  logic              str_temp_to_write,
  input  logic              rst_output_row_temp,
  input  logic              rst_dut_sram_write_address,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic [ADDR_W-1:0] word_count,
  output logic              addr_wrap_err
);

  localparam int                PACK      = DATA_W / RES_W;
  localparam int                SLOT_W    = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PACK - 1);

  typedef enum logic {S_FILL, S_COMMIT} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] stage_q, stage_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wcount_q, wcount_d;
  logic              wrap_q, wrap_d;
  logic [31:0]       shamt;
  logic [DATA_W-1:0] merged;

  // Slot 0 lands in the top RES_W bits of the word.
  assign shamt  = 32'(DATA_W - RES_W) - 32'(slot_q) * 32'(RES_W);
  assign merged = stage_q | (DATA_W'(conv_result) << shamt);

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    pend_d       = pend_q;
    slot_d       = slot_q;
    pend_valid_d = pend_valid_q;
    addr_d       = addr_q;
    wcount_d     = wcount_q;
    wrap_d       = wrap_q;

    case (state_q)
      S_FILL: begin
        if (pend_valid_q && str_temp_to_write) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d      = S_FILL;
        pend_valid_d = 1'b0;
        addr_d       = addr_q + 1'b1;
        wcount_d     = wcount_q + 1'b1;
        if (&addr_q) wrap_d = 1'b1;
      end
      default: state_d = S_FILL;
    endcase

    // Address reset beats the commit increment; the write itself already happened this cycle.
    if (rst_dut_sram_write_address) begin
      addr_d   = ADDR_BASE;
      wcount_d = '0;
      wrap_d   = 1'b0;
    end

    if (rst_output_row_temp) begin
      stage_d = '0;
      slot_d  = '0;
    end else if (conv_valid) begin
      if (slot_q == SLOT_LAST || row_last) begin
        pend_d       = merged;
        pend_valid_d = 1'b1;
        stage_d      = '0;
        slot_d       = '0;
      end else begin
        stage_d = merged;
        slot_d  = slot_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= S_FILL;
      stage_q      <= '0;
      pend_q       <= '0;
      slot_q       <= '0;
      pend_valid_q <= 1'b0;
      addr_q       <= ADDR_BASE;
      wcount_q     <= '0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      pend_q       <= pend_d;
      slot_q       <= slot_d;
      pend_valid_q <= pend_valid_d;
      addr_q       <= addr_d;
      wcount_q     <= wcount_d;
      wrap_q       <= wrap_d;
    end
  end

  assign dut_sram_write_enable  = (state_q == S_COMMIT);
  assign dut_sram_write_address = addr_q;
  assign dut_sram_write_data    = pend_q;
  assign word_count             = wcount_q;
  assign addr_wrap_err          = wrap_q;

endmodule

// File: tb/tb_conv_output_writer.sv
// tb/tb_conv_output_writer.sv - self-checking bench for conv_output_writer
// Directed vector table, hand-written commit/wrap/reset sequences, then random traffic against a row model.
module tb_conv_output_writer;

  logic        clk;
  logic        reset_b;
  logic        conv_valid;
  logic [0:0]  conv_result;
  logic        row_last;
  logic        str_temp_to_write;
  logic        rst_output_row_temp;
  logic        rst_dut_sram_write_address;
  logic        we;
  logic [11:0] waddr;
  logic [15:0] wdata;
  logic [11:0] wcount;
  logic        werr;

  int checks = 0;
  int errors = 0;

  conv_output_writer dut (
    .clk                        (clk),
    .reset_b                    (reset_b),
    .conv_valid                 (conv_valid),
    .conv_result                (conv_result),
    .row_last                   (row_last),
    .str_temp_to_write          (str_temp_to_write),
    .rst_output_row_temp        (rst_output_row_temp),
    .rst_dut_sram_write_address (rst_dut_sram_write_address),
    .dut_sram_write_enable      (we),
    .dut_sram_write_address     (waddr),
    .dut_sram_write_data        (wdata),
    .word_count                 (wcount),
    .addr_wrap_err              (werr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cv, res, rl, str, rrow, raddr;
    logic        we;
    logic [15:0] data;
    logic [11:0] addr, wc;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic cv, logic res, logic rl, logic str, logic rrow, logic raddr,
                              logic e_we, logic [15:0] e_data, logic [11:0] e_addr,
                              logic [11:0] e_wc, logic e_err);
    vec_t v;
    v.cv = cv; v.res = res; v.rl = rl; v.str = str; v.rrow = rrow; v.raddr = raddr;
    v.we = e_we; v.data = e_data; v.addr = e_addr; v.wc = e_wc; v.err = e_err;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic res, input logic rl, input logic str,
                       input logic rrow, input logic raddr);
    conv_valid = cv; conv_result = res; row_last = rl; str_temp_to_write = str;
    rst_output_row_temp = rrow; rst_dut_sram_write_address = raddr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One single-element row committed at the current address.
  task automatic commit_one();
    drive(1, 1, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0); tick();
    chk("bulk_we", 32'(we), 32'd1);
    drive(0, 0, 0, 0, 0, 0); tick();
  endtask

  // Behavioural reference: a row is a list of result bits, packed when full or on row_last.
  logic        m_comm, m_pend, m_err;
  logic [15:0] m_pendw;
  logic [11:0] m_addr, m_wc;
  logic        m_row[$];

  function automatic logic [15:0] pack_row();
    logic [15:0] w = '0;
    for (int i = 0; i < m_row.size(); i++) w[15-i] = m_row[i];
    return w;
  endfunction

  initial begin
    logic [15:0] pat;
    logic        cv, res, rl, str, rrow, raddr, n_comm;

    reset_b = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_we", 32'(we), 0);
    chk("reset_addr", 32'(waddr), 0);
    chk("reset_data", 32'(wdata), 0);
    chk("reset_wc", 32'(wcount), 0);
    chk("reset_err", 32'(werr), 0);
    @(negedge clk);
    reset_b = 1'b1;

    pat = 16'b1011_0000_1111_0101;
    for (int i = 0; i < 16; i++) add(1, pat[15-i], 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 16'hB0F5, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) add(1, 1, i == 4, 0, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0, 1, 16'hF800, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 2, 2, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 2, 2, 0);
    for (int i = 0; i < 16; i++) add(1, 1, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    add(0, 0, 0, 1, 0, 0, 1, 16'hFFFF, 2, 2, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0);

    foreach (tbl[k]) begin
      drive(tbl[k].cv, tbl[k].res, tbl[k].rl, tbl[k].str, tbl[k].rrow, tbl[k].raddr);
      tick();
      chk($sformatf("vec%0d_we", k), 32'(we), 32'(tbl[k].we));
      if (tbl[k].we) chk($sformatf("vec%0d_data", k), 32'(wdata), 32'(tbl[k].data));
      chk($sformatf("vec%0d_addr", k), 32'(waddr), 32'(tbl[k].addr));
      chk($sformatf("vec%0d_wc", k), 32'(wcount), 32'(tbl[k].wc));
      chk($sformatf("vec%0d_err", k), 32'(werr), 32'(tbl[k].err));
    end

    // Address reset coincident with the commit cycle at address 7.
    drive(0, 0, 0, 0, 0, 1); tick();
    chk("araddr_addr", 32'(waddr), 0);
    chk("araddr_wc", 32'(wcount), 0);
    drive(0, 0, 0, 0, 0, 0);
    repeat (7) commit_one();
    chk("pre7_addr", 32'(waddr), 7);
    drive(1, 1, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0); tick();
    chk("coinc_we", 32'(we), 1);
    chk("coinc_waddr", 32'(waddr), 7);
    chk("coinc_data", 32'(wdata), 32'h8000);
    drive(0, 0, 0, 0, 0, 1); tick();
    chk("coinc_we_drop", 32'(we), 0);
    chk("coinc_addr", 32'(waddr), 0);
    chk("coinc_wc", 32'(wcount), 0);
    drive(0, 0, 0, 0, 0, 0);

    // Walk to all-ones, then wrap.
    repeat (4095) commit_one();
    chk("pre_wrap_addr", 32'(waddr), 32'hFFF);
    chk("pre_wrap_err", 32'(werr), 0);
    drive(1, 1, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0); tick();
    chk("wrap_we", 32'(we), 1);
    chk("wrap_waddr", 32'(waddr), 32'hFFF);
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("wrap_addr", 32'(waddr), 0);
    chk("wrap_err", 32'(werr), 1);
    chk("wrap_wc", 32'(wcount), 0);
    drive(1, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("async_pre_we", 32'(we), 1);
    chk("sticky_err", 32'(werr), 1);
    #2;
    reset_b = 1'b0;
    #1;
    chk("async_we", 32'(we), 0);
    chk("async_addr", 32'(waddr), 0);
    chk("async_wc", 32'(wcount), 0);
    chk("async_err", 32'(werr), 0);
    chk("async_data", 32'(wdata), 0);
    @(negedge clk);
    reset_b = 1'b1;

    // Random traffic against the row model; one completion per commit at most.
    m_comm = 0; m_pend = 0; m_err = 0; m_pendw = 0; m_addr = 0; m_wc = 0;
    m_row.delete();
    for (int c = 0; c < 3000; c++) begin
      cv    = !m_pend && ($urandom_range(0, 9) < 7);
      res   = 1'($urandom);
      rl    = ($urandom_range(0, 9) == 0);
      str   = ($urandom_range(0, 9) < 3);
      rrow  = ($urandom_range(0, 19) == 0);
      raddr = ($urandom_range(0, 29) == 0);
      drive(cv, res, rl, str, rrow, raddr);

      n_comm = !m_comm && m_pend && str;
      if (m_comm) begin
        if (m_addr == 12'hFFF) m_err = 1;
        m_addr = m_addr + 1;
        m_wc   = m_wc + 1;
        m_pend = 0;
      end
      if (raddr) begin
        m_addr = 0; m_wc = 0; m_err = 0;
      end
      if (rrow) m_row.delete();
      else if (cv) begin
        m_row.push_back(res);
        if (m_row.size() == 16 || rl) begin
          m_pendw = pack_row();
          m_pend  = 1;
          m_row.delete();
        end
      end
      m_comm = n_comm;

      tick();
      chk("rnd_we", 32'(we), 32'(m_comm));
      if (m_comm) chk("rnd_data", 32'(wdata), 32'(m_pendw));
      chk("rnd_addr", 32'(waddr), 32'(m_addr));
      chk("rnd_wc", 32'(wcount), 32'(m_wc));
      chk("rnd_err", 32'(werr), 32'(m_err));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
